// File: rtl/prog_loader_ctrl_pkg.sv
// Shared definitions for the program loader: FSM state encoding, error codes
// and the frame-length admission rule.
package prog_loader_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LEN = 3'd0,
    ST_LOAD     = 3'd1,
    ST_CHECK    = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERR      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  // A frame fits when it is non-empty and its last byte lands inside the RAM.
  function automatic logic len_fits(input int unsigned len,
                                    input int unsigned base,
                                    input int unsigned addr_w);
    return (len != 0) && ((base + len) <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/load_idle_timer.sv
// Idle-gap watchdog for an in-progress frame: counts cycles without an
// accepted byte and flags expiry at TIMEOUT_CYC-1. TIMEOUT_CYC==0 disables it.
module load_idle_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYC == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, clear, enable};
    assign expired       = 1'b0;
  end else begin : g_on
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] timer_q;

    // Held at zero outside LOAD/CHECK so every entry starts a fresh count.
    always_ff @(posedge clk) begin
      if (reset || clear || !enable) timer_q <= '0;
      else                           timer_q <= timer_q + TW'(1);
    end

    assign expired = enable && (timer_q == TW'(TIMEOUT_CYC - 1));
  end

endmodule

// File: rtl/prog_loader_ctrl.sv
// Boot sequencer: holds the CPU in reset, streams a length/payload/checksum
// frame into program RAM and releases the CPU only on a matching checksum.
module prog_loader_ctrl
  import prog_loader_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output state_e            dbg_state
);

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
  // rx_ready depends only on state and start, never on rx_valid.

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              accept;
  logic              timer_en;
  logic              expired;

  assign accept   = rx_valid && rx_ready;
  assign timer_en = (state_q == ST_LOAD) || (state_q == ST_CHECK);

  load_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept || start),
    .enable (timer_en),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT_LEN;
      err_q       <= ERR_NONE;
      len_q       <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= ADDR_W'(BASE_ADDR);
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    len_d       = len_q;
    sum_d       = sum_q;
    count_d     = count_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (start) begin
      state_d = ST_WAIT_LEN;
      err_d   = ERR_NONE;
      sum_d   = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        ST_WAIT_LEN: begin
          if (accept) begin
            len_d = rx_data;
            if (len_fits(32'(rx_data), BASE_ADDR, ADDR_W)) begin
              state_d = ST_LOAD;
              sum_d   = '0;
              count_d = '0;
            end else begin
              state_d = ST_ERR;
              err_d   = ERR_LEN;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(count_q);
            ram_wdata_d = rx_data;
            sum_d       = sum_q + rx_data;
            count_d     = count_q + DATA_W'(1);
            if (count_q == len_q - DATA_W'(1)) state_d = ST_CHECK;
          end else if (expired) begin
            state_d = ST_ERR;
            err_d   = ERR_TIMEOUT;
          end
        end
        ST_CHECK: begin
          if (accept) begin
            if (rx_data == sum_q) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_ERR;
              err_d   = ERR_CSUM;
            end
          end else if (expired) begin
            state_d = ST_ERR;
            err_d   = ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rx_ready  = !start && ((state_q == ST_WAIT_LEN) || (state_q == ST_LOAD) ||
                           (state_q == ST_CHECK));
    cpu_reset = (state_q != ST_RUN);
    done      = (state_q == ST_RUN);
    error     = (state_q == ST_ERR);
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign err_code  = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Bench for prog_loader_ctrl: table rows, random frames against a frame-level
// model, and hand-written timeout / abort / boundary sequences.
module tb_prog_loader_ctrl;
  import prog_loader_ctrl_pkg::*;

  localparam int BASE_A = 0;
  localparam int TO_A   = 16;
  localparam int BASE_B = 250;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, rx_valid, rx_ready;
  logic [7:0] rx_data;
  logic       ram_we, cpu_reset, done, error;
  logic [7:0] ram_addr, ram_wdata;
  logic [1:0] err_code;
  state_e     dbg_state;

  logic       b_reset, b_start, b_rx_valid, b_rx_ready;
  logic [7:0] b_rx_data;
  logic       b_ram_we, b_cpu_reset, b_done, b_error;
  logic [7:0] b_ram_addr, b_ram_wdata;
  logic [1:0] b_err_code;
  state_e     b_dbg_state;

  prog_loader_ctrl #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(BASE_A), .TIMEOUT_CYC(TO_A)) u_dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .err_code(err_code),
    .dbg_state(dbg_state)
  );

  prog_loader_ctrl #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(BASE_B), .TIMEOUT_CYC(0)) u_dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .rx_ready(b_rx_ready), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .cpu_reset(b_cpu_reset), .done(b_done), .error(b_error), .err_code(b_err_code),
    .dbg_state(b_dbg_state)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [47:0] exp_q[$];
  logic [47:0] wr_q[$];
  logic [15:0] b_wr_q[$];
  logic [7:0]  mem[256];
  logic [7:0]  frm[$];

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_q.push_back({cyc, ram_addr, ram_wdata});
      mem[ram_addr] = ram_wdata;
    end
    if (b_ram_we === 1'b1) b_wr_q.push_back({b_ram_addr, b_ram_wdata});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_writes(input string name);
    chk({name, " write count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      chk({name, " write {cycle,addr,data}"}, 64'(wr_q[i]), 64'(exp_q[i]));
    wr_q.delete();
    exp_q.delete();
  endtask

  // Frame-level reference: length rule, payload placement and 8-bit checksum.
  task automatic model_frame(output int n_send, output logic [1:0] m_err,
                             output logic m_done);
    int L = int'(frm[0]);
    int s = 0;
    if (L == 0 || BASE_A + L > 256) begin
      n_send = 1; m_err = 2'd1; m_done = 1'b0;
    end else begin
      for (int i = 1; i <= L; i++) s = (s + int'(frm[i])) % 256;
      n_send = L + 2;
      m_err  = (int'(frm[L+1]) == s) ? 2'd0 : 2'd2;
      m_done = (m_err == 2'd0);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input string name);
    @(negedge clk);
    start = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    chk({name, " start cpu_reset"}, cpu_reset, 1'b1);
    chk({name, " start done"}, done, 1'b0);
    chk({name, " start error"}, error, 1'b0);
    chk({name, " start err_code"}, err_code, 2'd0);
    chk({name, " start state"}, dbg_state, ST_WAIT_LEN);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ok, output int acc_cyc);
    int budget = 0;
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    while (rx_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    ok = (rx_ready === 1'b1);
    acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic run_frame(input string name, input int gap);
    int n_send, ac;
    logic [1:0] m_err;
    logic m_done, ok, all_ok;
    int L = int'(frm[0]);
    all_ok = 1'b1;
    model_frame(n_send, m_err, m_done);
    for (int i = 0; i < n_send; i++) begin
      if (i == n_send - 1 && n_send > 1) begin
        #1;
        chk({name, " cpu held before checksum"}, cpu_reset, 1'b1);
      end
      send_byte(frm[i], ok, ac);
      all_ok &= ok;
      if (i >= 1 && i <= L && m_err != 2'd1)
        exp_q.push_back({32'(ac + 1), 8'(BASE_A + i - 1), frm[i]});
      if (gap > 0 && i < n_send - 1) idle(gap);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk({name, " all bytes accepted"}, all_ok, 1'b1);
    chk({name, " cpu_reset"}, cpu_reset, !m_done);
    chk({name, " done"}, done, m_done);
    chk({name, " error"}, error, !m_done);
    chk({name, " err_code"}, err_code, m_err);
    chk({name, " rx_ready after frame"}, rx_ready, 1'b0);
    check_writes(name);
  endtask

  task automatic build_frame(input int len, input logic bad);
    int s = 0;
    frm.delete();
    frm.push_back(8'(len));
    if (len != 0) begin
      for (int i = 0; i < len; i++) begin
        frm.push_back(8'($urandom_range(0, 255)));
        s = s + int'(frm[i+1]);
      end
      frm.push_back(8'(s + (bad ? $urandom_range(1, 255) : 0)));
    end
  endtask

  typedef struct {
    int         len;
    int         gap;
    logic       bad;
    logic       exp_done;
    logic [1:0] exp_err;
  } vec_t;

  vec_t tbl[6];

  // ---------------- test sequence ----------------
  initial begin
    logic ok;
    int ac, ac0;
    logic [7:0] bp[8];
    int bs;
    b_reset = 1'b1; b_start = 1'b0; b_rx_valid = 1'b0; b_rx_data = '0;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;

    tbl[0] = '{len: 3,   gap: 0, bad: 1'b0, exp_done: 1'b1, exp_err: 2'd0};
    tbl[1] = '{len: 1,   gap: 0, bad: 1'b0, exp_done: 1'b1, exp_err: 2'd0};
    tbl[2] = '{len: 5,   gap: 2, bad: 1'b0, exp_done: 1'b1, exp_err: 2'd0};
    tbl[3] = '{len: 4,   gap: 1, bad: 1'b1, exp_done: 1'b0, exp_err: 2'd2};
    tbl[4] = '{len: 0,   gap: 0, bad: 1'b0, exp_done: 1'b0, exp_err: 2'd1};
    tbl[5] = '{len: 255, gap: 0, bad: 1'b0, exp_done: 1'b1, exp_err: 2'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", dbg_state, ST_WAIT_LEN);
    chk("reset cpu_reset", cpu_reset, 1'b1);
    chk("reset done", done, 1'b0);
    chk("reset error", error, 1'b0);
    chk("reset err_code", err_code, 2'd0);
    chk("reset ram_we", ram_we, 1'b0);
    chk("reset ram_addr", ram_addr, 8'(BASE_A));
    chk("reset ram_wdata", ram_wdata, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    chk("reset rx_ready", rx_ready, 1'b1);

    // Basic frame, bytes back to back
    frm = '{8'h03, 8'h01, 8'h0A, 8'h05, 8'h10};
    run_frame("basic", 0);

    // Checksum wraps modulo 256; mismatch, then recovery via start
    pulse_start("csum");
    frm = '{8'h02, 8'hFF, 8'h02, 8'h02};
    run_frame("csum_bad", 0);
    pulse_start("recover");
    frm = '{8'h02, 8'hFF, 8'h02, 8'h01};
    run_frame("csum_good", 0);

    // Zero length
    pulse_start("len0");
    frm = '{8'h00};
    run_frame("len0", 0);

    // Idle timeout: expires exactly TO_A edges after the last accept
    pulse_start("tmo");
    send_byte(8'h04, ok, ac);
    send_byte(8'hAA, ok, ac0);
    exp_q.push_back({32'(ac0 + 1), 8'(BASE_A), 8'hAA});
    for (int k = 1; k <= TO_A + 1; k++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (k >= TO_A - 1)
        chk($sformatf("timeout err_code k=%0d", k), err_code, (k == TO_A + 1) ? 2'd3 : 2'd0);
    end
    chk("timeout error", error, 1'b1);
    chk("timeout cpu_reset", cpu_reset, 1'b1);
    check_writes("timeout");

    // A byte landing on the last idle cycle beats the timeout
    pulse_start("tmo_edge");
    frm = '{8'h04, 8'hAA, 8'h11, 8'h22, 8'h33, 8'h10};
    send_byte(frm[0], ok, ac);
    send_byte(frm[1], ok, ac);
    exp_q.push_back({32'(ac + 1), 8'd0, frm[1]});
    idle(TO_A - 1);
    for (int i = 2; i < 6; i++) begin
      send_byte(frm[i], ok, ac);
      chk($sformatf("tmo_edge accept %0d", i), ok, 1'b1);
      if (i <= 4) exp_q.push_back({32'(ac + 1), 8'(i - 1), frm[i]});
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("tmo_edge done", done, 1'b1);
    chk("tmo_edge err_code", err_code, 2'd0);
    check_writes("tmo_edge");

    // start mid-LOAD while a byte is offered
    pulse_start("abort");
    send_byte(8'h05, ok, ac);
    send_byte(8'h21, ok, ac);
    exp_q.push_back({32'(ac + 1), 8'd0, 8'h21});
    send_byte(8'h22, ok, ac);
    exp_q.push_back({32'(ac + 1), 8'd1, 8'h22});
    @(negedge clk);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    #1;
    chk("abort rx_ready on start", rx_ready, 1'b0);
    @(negedge clk);
    chk("abort state", dbg_state, ST_WAIT_LEN);
    chk("abort cpu_reset", cpu_reset, 1'b1);
    chk("abort err_code", err_code, 2'd0);
    start = 1'b0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_writes("abort");
    chk("abort ram[0] kept", mem[0], 8'h21);
    chk("abort ram[1] kept", mem[1], 8'h22);
    frm = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
    run_frame("after_abort", 0);

    // reset arriving with a payload accept cancels that write
    pulse_start("rst_mid");
    send_byte(8'h03, ok, ac);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h55; reset = 1'b1;
    @(negedge clk);
    chk("rst_mid ram_we", ram_we, 1'b0);
    chk("rst_mid state", dbg_state, ST_WAIT_LEN);
    reset = 1'b0; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_writes("rst_mid");

    // Table rows
    for (int t = 0; t < 6; t++) begin
      pulse_start($sformatf("tbl%0d", t));
      build_frame(tbl[t].len, tbl[t].bad);
      run_frame($sformatf("tbl%0d", t), tbl[t].gap);
      chk($sformatf("tbl%0d table done", t), done, tbl[t].exp_done);
      chk($sformatf("tbl%0d table err_code", t), err_code, tbl[t].exp_err);
    end

    // Random frames against the model
    for (int r = 0; r < 20; r++) begin
      int len;
      pulse_start($sformatf("rnd%0d", r));
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 30);
      build_frame(len, $urandom_range(0, 3) == 0);
      run_frame($sformatf("rnd%0d", r), $urandom_range(0, 3));
    end

    // Second instance: high base address, timeout disabled
    @(negedge clk);
    b_reset = 1'b0;
    b_rx_valid = 1'b1; b_rx_data = 8'h07;
    @(negedge clk);
    b_rx_valid = 1'b0;
    chk("base250 len7 err_code", b_err_code, 2'd1);
    chk("base250 len7 error", b_error, 1'b1);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    bs = 0;
    bp[0] = 8'h06;
    for (int i = 1; i <= 6; i++) begin
      bp[i] = 8'($urandom_range(0, 255));
      bs = bs + int'(bp[i]);
    end
    bp[7] = 8'(bs);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_rx_valid = 1'b1; b_rx_data = bp[i];
      ok &= (b_rx_ready === 1'b1);
      if (i == 3) begin
        @(negedge clk);
        b_rx_valid = 1'b0;
        repeat (40) @(negedge clk);
      end
    end
    @(negedge clk);
    b_rx_valid = 1'b0;
    chk("base250 all accepted", ok, 1'b1);
    chk("base250 done", b_done, 1'b1);
    chk("base250 cpu_reset", b_cpu_reset, 1'b0);
    chk("base250 err_code", b_err_code, 2'd0);
    chk("base250 write count", 64'(b_wr_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < b_wr_q.size(); i++)
      chk($sformatf("base250 write %0d", i), b_wr_q[i], {8'(BASE_B + i), bp[i+1]});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prog_loader_ctrl.md
Name: prog_loader_ctrl

Overview:
Boot/program-load sequencer for the Microprocessor core. It holds the CPU in reset and accepts a byte-stream frame (length, payload, checksum) over a valid/ready handshake. Payload bytes are written into the CPU's program RAM through a dedicated write port. The CPU is released from reset only when the frame's checksum verifies. This replaces direct hierarchical RAM preloading and sits between the host/UART byte source and the Microprocessor's RAM and reset pins.

Parameters:
ADDR_W, 8, RAM address width; RAM depth = 2**ADDR_W
DATA_W, 8, byte/word width of stream and RAM
BASE_ADDR, 0, RAM address of the first payload byte
TIMEOUT_CYC, 1000, max idle cycles between bytes inside a frame; 0 disables timeout

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse: abort/restart load, re-enter WAIT_LEN
rx_data  in  DATA_W  incoming stream byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  controller can accept a byte this cycle
ram_we  out  1  RAM write strobe, one cycle per payload byte
ram_addr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
cpu_reset  out  1  drives Microprocessor reset; 1 = CPU held
done  out  1  frame loaded and verified, CPU running
error  out  1  frame rejected, CPU held
err_code  out  2  0 none, 1 bad length, 2 checksum mismatch, 3 timeout

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high. Reset state: WAIT_LEN, cpu_reset=1, done=0, error=0, err_code=0, ram_we=0, ram_addr=BASE_ADDR, ram_wdata=0, sum=0, count=0, timer=0.
- Byte accept: rx_valid && rx_ready at a rising edge. rx_ready = (state in WAIT_LEN, LOAD, CHECK) && !start. It is combinational from state and start, with no dependence on rx_valid.
- WAIT_LEN: accepted byte L is stored as len.
  - L==0, or BASE_ADDR+L > 2**ADDR_W -> ERR with err_code=1.
  - Otherwise -> LOAD with count=0 and sum=0.
  - No timeout in this state.
- LOAD: each accepted byte b, registered:
  - ram_we=1 next cycle, ram_addr=BASE_ADDR+count, ram_wdata=b.
  - sum <= (sum+b) mod 2**DATA_W; count++.
  - Write latency is exactly 1 cycle after acceptance. ram_we is otherwise 0.
  - After the L-th byte -> CHECK.
- CHECK: accepted byte c.
  - c==sum -> RUN.
  - Else -> ERR with err_code=2.
- RUN: cpu_reset=0, done=1. cpu_reset falls on the cycle after the checksum byte is accepted. rx_ready=0.
- ERR: cpu_reset=1, error=1, rx_ready=0. Remains in ERR until start or reset.
- Timeout (TIMEOUT_CYC>0, states LOAD/CHECK only):
  - timer clears on every accepted byte and on state entry, and increments otherwise.
  - When timer reaches TIMEOUT_CYC-1 without an accept -> ERR with err_code=3.
  - An accept in that same cycle wins and no timeout occurs.
- start, in any state: -> WAIT_LEN next cycle.
  - cpu_reset=1 in that same next cycle. done, error and err_code clear; sum, count and timer clear.
  - Bytes already written stay in RAM. No write occurs for a byte offered on the start cycle (rx_ready=0).
- reset mid-frame: same as start, plus a pending ram_we is cancelled.
- Address never exceeds 2**ADDR_W-1, guaranteed by the length check. No wrap-around is permitted.
- Back-to-back bytes (rx_valid held high) are accepted every cycle in LOAD, giving one ram_we per cycle.

Decomposition:
- Shared include mp_defs.vh holds:
  - state encodings ST_WAIT_LEN, ST_LOAD, ST_CHECK, ST_RUN, ST_ERR (3-bit);
  - err codes ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT;
  - opcode constants shared with the Microprocessor.
- One natural sub-module: load_idle_timer. It takes clk, reset, clear and enable, and outputs expired. It is parameterized by TIMEOUT_CYC and ties expired=0 when TIMEOUT_CYC==0.
- FSM, checksum and write registers stay in prog_loader_ctrl.

Test Plan:
1. Reset, then stream 0x03, 0x01, 0x0A, 0x05, 0x10 with rx_valid held high -> ram writes (0,0x01), (1,0x0A), (2,0x05) on consecutive cycles. cpu_reset falls 1 cycle after 0x10 is accepted; done=1, error=0.
2. Stream 0x02, 0xFF, 0x02, checksum 0x02 (wrap: 0xFF+0x02=0x01) -> err_code=2, error=1, cpu_reset stays 1. Then pulse start and send a valid frame -> done=1.
3. Length 0x00 -> ERR, err_code=1, no ram_we. With BASE_ADDR=250, length 0x07 -> err_code=1.
4. TIMEOUT_CYC=16: send 0x04, 0xAA, then idle 20 cycles -> err_code=3 exactly 16 cycles after the 0xAA accept. A byte arriving on cycle 15 of the gap keeps loading.
5. Mid-LOAD (2 of 5 bytes sent), start pulsed while rx_valid=1 -> byte not accepted, WAIT_LEN next cycle, cpu_reset=1. ram[0..1] retain the written values.
6. Gaps in rx_valid (valid every 3rd cycle) during LOAD -> still exactly one ram_we per byte, with correct addresses and checksum; done=1.
